// File: rtl/barrel_scheduler.sv
// barrel_scheduler
//   Allocates barrel slots for Kong's drops. Each rising edge of drop_req
//   becomes a single pending request. The request is served by the first free
//   slot in round-robin order, starting at ptr. That slot's start line is held
//   until the barrel reports busy or the acknowledge timer expires. A cooldown
//   of GAP cycles then separates consecutive launches.
//
// Ports
//   clk           barrel update clock
//   rst           asynchronous active-high reset
//   enable        high while the game is RUNNING; low forces IDLE and drops work
//   drop_req      Kong drop strobe (level); acted on at its rising edge
//   slot_busy     per-slot ROLLING/FALLING status from the barrel array
//   start         one-hot (or zero) launch line, held until ack or timeout
//   launch_idx    slot currently or last launched
//   launch_count  acknowledged launches, wraps at 255
//   lost_count    requests dropped because one was already pending, saturates
//   active_count  registered popcount of slot_busy
//   all_busy      registered AND of slot_busy
//   ack_timeout   sticky flag: a launch was abandoned without acknowledge
module barrel_scheduler #(
    parameter int N_SLOTS     = 16,
    parameter int IDX_W       = 4,
    parameter int GAP         = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               drop_req,
    input  logic [N_SLOTS-1:0] slot_busy,
    output logic [N_SLOTS-1:0] start,
    output logic [IDX_W-1:0]   launch_idx,
    output logic [7:0]         launch_count,
    output logic [7:0]         lost_count,
    output logic [IDX_W:0]     active_count,
    output logic               all_busy,
    output logic               ack_timeout
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CW = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_COOLDOWN} state_t;

    state_t           state, state_n;
    logic             req_d, req_rise, pending;
    logic [IDX_W-1:0] ptr, cand, free_idx;
    logic             free_found;
    logic [TW-1:0]    tcnt;
    logic [GW-1:0]    ccnt;
    logic [CW-1:0]    busy_cnt;
    logic             launch_go, ack_ok, ack_abandon;

    assign req_rise = drop_req & ~req_d;

    // First free slot scanning upward from ptr, wrapping modulo N_SLOTS.
    always_comb begin
        free_found = 1'b0;
        free_idx   = ptr;
        cand       = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            cand = ptr + IDX_W'(k);
            if (!free_found && !slot_busy[cand]) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            busy_cnt = busy_cnt + CW'(slot_busy[k]);
        end
    end

    always_comb begin
        state_n     = state;
        launch_go   = 1'b0;
        ack_ok      = 1'b0;
        ack_abandon = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending && free_found) begin
                        launch_go = 1'b1;
                        state_n   = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (slot_busy[launch_idx]) begin
                        ack_ok  = 1'b1;
                        state_n = (GAP == 0) ? S_IDLE : S_COOLDOWN;
                    end else if (tcnt == '0) begin
                        ack_abandon = 1'b1;
                        state_n     = (GAP == 0) ? S_IDLE : S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (ccnt == GW'(1)) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d        <= 1'b0;
            pending      <= 1'b0;
            ptr          <= '0;
            tcnt         <= '0;
            ccnt         <= '0;
            start        <= '0;
            launch_idx   <= '0;
            launch_count <= '0;
            lost_count   <= '0;
            active_count <= '0;
            all_busy     <= 1'b0;
            ack_timeout  <= 1'b0;
        end else begin
            req_d        <= drop_req;
            active_count <= busy_cnt;
            all_busy     <= &slot_busy;
            if (!enable) begin
                pending <= 1'b0;
                start   <= '0;
            end else begin
                if (launch_go) begin
                    launch_idx <= free_idx;
                    tcnt       <= TW'(ACK_TIMEOUT);
                    start      <= N_SLOTS'(1) << free_idx;
                end else if (ack_ok || ack_abandon) begin
                    start <= '0;
                end

                if (state == S_LAUNCH && !ack_ok && !ack_abandon) begin
                    tcnt <= tcnt - TW'(1);
                end

                if (ack_ok) begin
                    launch_count <= launch_count + 8'd1;
                end
                if (ack_abandon) begin
                    ack_timeout <= 1'b1;
                end

                if (ack_ok || ack_abandon) begin
                    ptr  <= launch_idx + IDX_W'(1);
                    ccnt <= GW'(GAP);
                end else if (state == S_COOLDOWN) begin
                    ccnt <= ccnt - GW'(1);
                end

                // A rise coinciding with consumption re-arms pending instead of
                // being counted as lost.
                if (req_rise) begin
                    if (launch_go || !pending) begin
                        pending <= 1'b1;
                    end else if (lost_count != 8'hFF) begin
                        lost_count <= lost_count + 8'd1;
                    end
                end else if (launch_go) begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_barrel_scheduler.sv
module tb_barrel_scheduler;

    localparam int N    = 16;
    localparam int IW   = 4;
    localparam int GAPP = 8;
    localparam int TMO  = 15;
    localparam int LIFE = 3;
    localparam int VW   = N + IW + 16 + (IW + 1) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          drop_req = 1'b0;
    logic [N-1:0]  slot_busy = '0;
    logic [N-1:0]  start;
    logic [IW-1:0] launch_idx;
    logic [7:0]    launch_count;
    logic [7:0]    lost_count;
    logic [IW:0]   active_count;
    logic          all_busy;
    logic          ack_timeout;

    int checks = 0;
    int errors = 0;

    barrel_scheduler #(
        .N_SLOTS(N),
        .IDX_W(IW),
        .GAP(GAPP),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .drop_req(drop_req),
        .slot_busy(slot_busy),
        .start(start),
        .launch_idx(launch_idx),
        .launch_count(launch_count),
        .lost_count(lost_count),
        .active_count(active_count),
        .all_busy(all_busy),
        .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    // Bench-side barrel array: forced busy bits plus barrels that start
    // rolling (for LIFE cycles) one cycle after their start line is seen.
    logic [N-1:0] force_busy = '0;
    bit           auto_ack = 1'b1;
    int           life [N];

    // Reference model: a request queue of depth one, a launch in flight with
    // its age, and a cooldown countdown.
    bit m_req_d, m_pending, m_launching, m_timeout, m_all;
    int m_ptr, m_slot, m_age, m_cool, m_launches, m_lost, m_idx, m_active;

    task automatic model_step();
        bit rise;
        int pick;
        if (rst) begin
            m_req_d = 0; m_pending = 0; m_launching = 0; m_timeout = 0; m_all = 0;
            m_ptr = 0; m_slot = 0; m_age = 0; m_cool = 0;
            m_launches = 0; m_lost = 0; m_idx = 0; m_active = 0;
            return;
        end
        rise     = drop_req && !m_req_d;
        m_req_d  = drop_req;
        m_active = $countones(slot_busy);
        m_all    = (slot_busy == {N{1'b1}});
        if (!enable) begin
            m_launching = 0;
            m_cool      = 0;
            m_pending   = 0;
            return;
        end
        if (m_launching) begin
            if (slot_busy[m_slot]) begin
                m_launches  = (m_launches + 1) % 256;
                m_launching = 0;
                m_cool      = GAPP;
                m_ptr       = (m_slot + 1) % N;
            end else if (m_age >= TMO) begin
                m_timeout   = 1;
                m_launching = 0;
                m_cool      = GAPP;
                m_ptr       = (m_slot + 1) % N;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_pending) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && !slot_busy[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            if (pick >= 0) begin
                m_slot = pick; m_idx = pick;
                m_launching = 1; m_age = 0; m_pending = 0;
            end
        end
        if (rise) begin
            if (!m_pending) m_pending = 1;
            else if (m_lost < 255) m_lost++;
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0] s;
        s = m_launching ? (N'(1) << m_slot) : '0;
        return {s, IW'(m_idx), 8'(m_launches), 8'(m_lost), (IW + 1)'(m_active), m_all, m_timeout};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {start, launch_idx, launch_count, lost_count, active_count, all_busy, ack_timeout};
    endfunction

    task automatic drive_busy();
        logic [N-1:0] v;
        v = force_busy;
        for (int i = 0; i < N; i++) if (life[i] > 0) v[i] = 1'b1;
        slot_busy = v;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (life[i] > 0) life[i]--;
            if (auto_ack && start[i] && life[i] == 0) life[i] = LIFE;
        end
        drive_busy();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; enable = 0; drop_req = 0; force_busy = '0; auto_ack = 1;
        for (int i = 0; i < N; i++) life[i] = 0;
        drive_busy();
        @(negedge clk);
        @(negedge clk);
        rst = 0; enable = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; enable = 1; drop_req = 1; force_busy = '0; auto_ack = 1;
        for (int i = 0; i < N; i++) life[i] = 0;
        drive_busy();
        @(negedge clk);
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        rst = 0;
        tick();
        drop_req = 0;
        tick();
        checks++;
        if (start !== 16'h0001) begin
            errors++;
            $display("FAIL reset_release_rise start got=%h exp=0001", start);
        end
        repeat (4) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_reset t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        drop_req = 1;
        tick();
        drop_req = 0;
        checks++;
        if (start !== '0) begin
            errors++;
            $display("FAIL basic_early start got=%h exp=0000", start);
        end
        tick();
        checks++;
        if (start !== 16'h0001) begin
            errors++;
            $display("FAIL basic_first start got=%h exp=0001", start);
        end
        tick();
        checks++;
        if (launch_count !== 8'd1 || start !== '0) begin
            errors++;
            $display("FAIL basic_ack launch_count=%0d start=%h exp 1/0000", launch_count, start);
        end
        repeat (GAPP + 4) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_basic t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        drop_req = 1;
        tick();
        drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_basic2 t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        checks++;
        if (start !== 16'h0002) begin
            errors++;
            $display("FAIL basic_second start got=%h exp=0002", start);
        end
    endtask

    task automatic test_skip_busy();
        int n;
        do_reset();
        force_busy = 16'hFFF7;
        drive_busy();
        drop_req = 1;
        tick();
        drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_skip t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        checks++;
        if (start !== 16'h0008 || launch_idx !== 4'd3 || all_busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_busy start=%h idx=%0d all_busy=%b exp 0008/3/0", start, launch_idx, all_busy);
        end
    endtask

    task automatic test_all_busy();
        int n;
        do_reset();
        force_busy = '1;
        drive_busy();
        repeat (3) begin
            drop_req = 1; tick();
            drop_req = 0; tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_allbusy t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        tick();
        checks++;
        if (start !== '0 || lost_count !== 8'd2 || all_busy !== 1'b1) begin
            errors++;
            $display("FAIL all_busy_hold start=%h lost=%0d all_busy=%b exp 0000/2/1", start, lost_count, all_busy);
        end
        force_busy = 16'hFFDF;
        drive_busy();
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
        end
        checks++;
        if (start !== 16'h0020) begin
            errors++;
            $display("FAIL all_busy_release start got=%h exp=0020", start);
        end
    endtask

    task automatic test_timeout();
        int n, hi;
        do_reset();
        auto_ack = 0;
        drop_req = 1; tick(); drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
        end
        hi = 0;
        while (start != '0 && hi < 40) begin
            hi++;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_timeout t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        checks++;
        if (hi !== TMO + 1) begin
            errors++;
            $display("FAIL timeout_width start high %0d cycles, exp %0d", hi, TMO + 1);
        end
        checks++;
        if (ack_timeout !== 1'b1 || launch_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_flags ack_timeout=%b launch_count=%0d exp 1/0", ack_timeout, launch_count);
        end
        auto_ack = 1;
        repeat (GAPP + 2) tick();
        drop_req = 1; tick(); drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
        end
        checks++;
        if (start !== 16'h0002) begin
            errors++;
            $display("FAIL timeout_ptr start got=%h exp=0002", start);
        end
    endtask

    task automatic test_disable();
        int n;
        do_reset();
        auto_ack = 0;
        drop_req = 1; tick(); drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
        end
        drop_req = 1; tick(); drop_req = 0;
        enable = 0;
        tick();
        checks++;
        if (start !== '0 || launch_count !== 8'd0 || lost_count !== 8'd0 || ack_timeout !== 1'b0) begin
            errors++;
            $display("FAIL disable_stop start=%h launch=%0d lost=%0d to=%b exp 0000/0/0/0",
                     start, launch_count, lost_count, ack_timeout);
        end
        drop_req = 1; tick(); drop_req = 0; tick();
        drop_req = 1; tick(); drop_req = 0; tick();
        checks++;
        if (lost_count !== 8'd0) begin
            errors++;
            $display("FAIL disable_lost lost_count got=%0d exp=0", lost_count);
        end
        enable = 1;
        auto_ack = 1;
        repeat (20) begin
            tick();
            checks++;
            if (start !== '0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL disable_pending_cleared t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_wrap_saturate();
        int n;
        logic [N-1:0] exp_start;
        do_reset();
        for (int j = 0; j < N - 1; j++) begin
            drop_req = 1; tick(); drop_req = 0;
            n = 0;
            while (start == '0 && n < 30) begin
                tick(); n++;
            end
            exp_start = N'(1) << j;
            checks++;
            if (start !== exp_start) begin
                errors++;
                $display("FAIL wrap_seq%0d start got=%h exp=%h", j, start, exp_start);
            end
            repeat (GAPP + 3) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL model_wrap t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
                end
            end
        end
        force_busy = 16'h8000;
        drive_busy();
        drop_req = 1; tick(); drop_req = 0;
        n = 0;
        while (start == '0 && n < 30) begin
            tick(); n++;
        end
        checks++;
        if (start !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_around start got=%h exp=0001", start);
        end
        force_busy = '1;
        drive_busy();
        repeat (GAPP + 3) tick();
        repeat (300) begin
            drop_req = 1; tick();
            drop_req = 0; tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_saturate t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        checks++;
        if (lost_count !== 8'd255) begin
            errors++;
            $display("FAIL lost_saturate lost_count got=%0d exp=255", lost_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            enable   = ($urandom_range(0, 24) != 0);
            drop_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) force_busy = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) force_busy = '1;
            if ($urandom_range(0, 99) == 0) auto_ack = ~auto_ack;
            drive_busy();
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL model_random t=%0t got=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_busy();
        test_all_busy();
        test_timeout();
        test_disable();
        test_wrap_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
